// File: rtl/eth_rx_fifo_read_mc_if.sv
// rtl/eth_rx_fifo_read_mc_if.sv - AXI-Stream-style output bus of the multi-channel RX frame-queue reader
interface eth_rx_fifo_read_mc_if #(
    parameter int DATA_W = 512,
    parameter int CH_W   = 1
);
    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [CH_W-1:0]   tdest;

    modport master (output tvalid, tdata, tkeep, tlast, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tdest, output tready);
endinterface

// File: rtl/eth_rx_fifo_read_mc.sv
// rtl/eth_rx_fifo_read_mc.sv - round-robin frame-granular reader of NUM_CH FWFT frame queues into one stream
module eth_rx_fifo_read_mc #(
    parameter int DATA_W = 512,
    parameter int NUM_CH = 2,
    localparam int KEEP_W = DATA_W / 8,
    localparam int WORD_W = DATA_W + KEEP_W + 1,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        frame_q_empty,
    output logic [NUM_CH-1:0]        frame_q_read,
    input  logic [NUM_CH*WORD_W-1:0] frame_q_dout,
    eth_rx_fifo_read_mc_if.master    so,
    output logic [31:0]              frame_cnt
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]             state;
    logic [CH_W-1:0]        gnt;
    logic [CH_W-1:0]        rr_ptr;
    logic [1:0]             occ;
    logic [CH_W+WORD_W-1:0] buf0;
    logic [CH_W+WORD_W-1:0] buf1;

    logic                   space;
    logic                   drain;
    logic                   cand_found;
    logic [CH_W-1:0]        cand_ch;
    int                     idx;
    logic                   pop;
    logic [CH_W-1:0]        pop_ch;
    logic [WORD_W-1:0]      pop_word;
    logic                   pop_last;
    logic [CH_W-1:0]        next_rr;

    assign space = (occ != 2'd2);
    assign drain = so.tvalid && so.tready;

    // First enabled, non-empty channel at or above rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        cand_found = 1'b0;
        cand_ch    = '0;
        idx        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_CH;
            if (!cand_found && ch_en[idx] && !frame_q_empty[idx]) begin
                cand_found = 1'b1;
                cand_ch    = CH_W'(idx);
            end
        end
    end

    // Pops are held off while in reset so no head word is lost to a discarded cycle.
    always_comb begin
        pop_ch       = (state == ST_STREAM) ? gnt : cand_ch;
        pop          = rstn && space &&
                       ((state == ST_STREAM) ? !frame_q_empty[gnt] : cand_found);
        pop_word     = frame_q_dout[int'(pop_ch)*WORD_W +: WORD_W];
        pop_last     = pop_word[WORD_W-1];
        frame_q_read = '0;
        if (pop) frame_q_read[pop_ch] = 1'b1;
    end

    assign next_rr = (pop_ch == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(pop_ch + 1'b1);

    assign so.tvalid = (occ != 2'd0);
    assign {so.tdest, so.tlast, so.tkeep, so.tdata} = buf0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            occ       <= 2'd0;
            frame_cnt <= 32'd0;
        end else begin
            if (pop) begin
                gnt <= pop_ch;
                if (pop_last) begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_rr;
                end else begin
                    state <= ST_STREAM;
                end
            end
            if (drain && buf0[WORD_W-1]) frame_cnt <= frame_cnt + 32'd1;
            // buf0 is always the oldest entry; buf1 only holds data when occ==2.
            case ({pop, drain})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= {pop_ch, pop_word};
                    else             buf1 <= {pop_ch, pop_word};
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= {pop_ch, pop_word};
                    end else begin
                        buf0 <= buf1;
                        buf1 <= {pop_ch, pop_word};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx_fifo_read_mc.sv
// tb/tb_eth_rx_fifo_read_mc.sv - scoreboard bench for the multi-channel RX frame-queue reader
module tb_eth_rx_fifo_read_mc;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int KEEP_W = DATA_W / 8;
    localparam int WORD_W = DATA_W + KEEP_W + 1;
    localparam int CH_W   = 2;
    localparam int ENT_W  = CH_W + WORD_W;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [NUM_CH-1:0]        ch_en = '0;
    logic [NUM_CH-1:0]        frame_q_empty = '1;
    logic [NUM_CH-1:0]        frame_q_read;
    logic [NUM_CH*WORD_W-1:0] frame_q_dout = '0;
    logic [31:0]              frame_cnt;

    eth_rx_fifo_read_mc_if #(.DATA_W(DATA_W), .CH_W(CH_W)) so_if ();

    eth_rx_fifo_read_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ch_en         (ch_en),
        .frame_q_empty (frame_q_empty),
        .frame_q_read  (frame_q_read),
        .frame_q_dout  (frame_q_dout),
        .so            (so_if),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] chq [NUM_CH][$];
    logic [ENT_W-1:0]  exp_q [$];
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic update_drv();
        for (int c = 0; c < NUM_CH; c++) begin
            frame_q_empty[c] = (chq[c].size() == 0);
            frame_q_dout[c*WORD_W +: WORD_W] = (chq[c].size() == 0) ? '0 : chq[c][0];
        end
    endtask

    task automatic load_frame(input int ch, input int len, input bit to_sb);
        logic [WORD_W-1:0] w;
        for (int i = 0; i < len; i++) begin
            w = {(i == len - 1), KEEP_W'($urandom_range(1, 15)), DATA_W'($urandom)};
            chq[ch].push_back(w);
            if (to_sb) exp_q.push_back({CH_W'(ch), w});
        end
        update_drv();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_tvalid", 64'(so_if.tvalid), 64'd0);
        check_eq("rst_read", 64'(frame_q_read), 64'd0);
        check_eq("rst_cnt", 64'(frame_cnt), 64'd0);
        for (int c = 0; c < NUM_CH; c++) chq[c].delete();
        exp_q.delete();
        update_drv();
        rstn = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || so_if.tvalid) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Upstream queue model: pops requested in a cycle take effect just after its closing edge.
    always @(posedge clk) begin
        logic [NUM_CH-1:0] m;
        m = frame_q_read;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                if (chq[c].size() > 0) void'(chq[c].pop_front());
                else check_eq("pop_empty", 64'd1, 64'd0);
            end
        end
        update_drv();
    end

    always @(negedge clk) begin
        logic [ENT_W-1:0] e;
        if (rstn && so_if.tvalid && so_if.tready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("beat", 64'({so_if.tdest, so_if.tlast, so_if.tkeep, so_if.tdata}), 64'(e));
            end
        end
    end

    initial begin
        int npop;
        so_if.tready = 1'b0;
        do_reset();

        // 3-word frame on ch0: first-beat latency and continuous streaming
        @(posedge clk); #2;
        ch_en = 4'b0001;
        so_if.tready = 1'b1;
        load_frame(0, 3, 1'b1);
        @(negedge clk);
        check_eq("t1_read0", 64'(frame_q_read), 64'h1);
        check_eq("t1_valid0", 64'(so_if.tvalid), 64'd0);
        @(negedge clk);
        check_eq("t1_read1", 64'(frame_q_read), 64'h1);
        check_eq("t1_valid1", 64'(so_if.tvalid), 64'd1);
        @(negedge clk);
        check_eq("t1_read2", 64'(frame_q_read), 64'h1);
        check_eq("t1_valid2", 64'(so_if.tvalid), 64'd1);
        @(negedge clk);
        check_eq("t1_read3", 64'(frame_q_read), 64'h0);
        check_eq("t1_last3", 64'(so_if.tlast), 64'd1);
        @(negedge clk);
        check_eq("t1_valid4", 64'(so_if.tvalid), 64'd0);
        check_eq("t1_cnt", 64'(frame_cnt), 64'd1);
        wait_drain("t1_drain");

        // two 2-word frames on each of ch0/ch1: frame-granular round robin
        do_reset();
        @(posedge clk); #2;
        ch_en = 4'b0011;
        load_frame(0, 2, 1'b1);
        load_frame(1, 2, 1'b1);
        load_frame(0, 2, 1'b1);
        load_frame(1, 2, 1'b1);
        wait_drain("t2_drain");
        check_eq("t2_cnt", 64'(frame_cnt), 64'd4);

        // backpressure for 5 cycles mid-frame
        do_reset();
        @(posedge clk); #2;
        ch_en = 4'b0001;
        load_frame(0, 8, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        so_if.tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t3_stall_read", 64'(frame_q_read), (k == 0) ? 64'h1 : 64'h0);
            if (exp_q.size() > 0)
                check_eq("t3_stable", 64'({so_if.tdest, so_if.tlast, so_if.tkeep, so_if.tdata}), 64'(exp_q[0]));
        end
        @(posedge clk); #2;
        so_if.tready = 1'b1;
        wait_drain("t3_drain");
        check_eq("t3_cnt", 64'(frame_cnt), 64'd1);

        // single-word frames on all channels: grant order 0,1,2,3,0
        do_reset();
        @(posedge clk); #2;
        ch_en = 4'b1111;
        load_frame(0, 1, 1'b1);
        load_frame(1, 1, 1'b1);
        load_frame(2, 1, 1'b1);
        load_frame(3, 1, 1'b1);
        load_frame(0, 1, 1'b1);
        wait_drain("t4_drain");
        check_eq("t4_cnt", 64'(frame_cnt), 64'd5);

        // only ch1 enabled; disabling it mid-frame still completes that frame
        do_reset();
        @(posedge clk); #2;
        ch_en = 4'b0010;
        load_frame(0, 2, 1'b0);
        load_frame(1, 4, 1'b1);
        load_frame(1, 2, 1'b0);
        @(posedge clk); #2;
        ch_en = 4'b0000;
        wait_drain("t5_drain");
        npop = 0;
        repeat (8) begin
            @(negedge clk);
            if (frame_q_read != '0) npop++;
        end
        check_eq("t5_no_grant", 64'(npop), 64'd0);
        check_eq("t5_ch0_left", 64'(chq[0].size()), 64'd2);
        check_eq("t5_ch1_left", 64'(chq[1].size()), 64'd2);
        check_eq("t5_cnt", 64'(frame_cnt), 64'd1);

        // reset in the middle of a ch1 frame, then arbitration restarts at ch0
        do_reset();
        @(posedge clk); #2;
        ch_en = 4'b0011;
        load_frame(0, 2, 1'b1);
        load_frame(1, 6, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        do_reset();
        @(posedge clk); #2;
        load_frame(0, 1, 1'b1);
        load_frame(1, 1, 1'b1);
        wait_drain("t6_drain");
        check_eq("t6_cnt", 64'(frame_cnt), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t exp=<200000", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/eth_rx_fifo_read_mc.md
Name: eth_rx_fifo_read_mc

Overview:
Multi-channel, width-parametrised successor to the RX frame-queue reader. It drains NUM_CH first-word-fall-through (FWFT) frame queues and emits one AXI-Stream master on so_*. Channels are arbitrated round-robin at frame granularity, so frames from different channels never interleave. A 2-entry output skid buffer gives full throughput with registered outputs, and so_tdest tags each beat with its source channel.

Parameters:
DATA_W, 512, stream data width in bits; must be a multiple of 8.
NUM_CH, 2, number of input frame queues; 1..16.
KEEP_W, DATA_W/8, derived; tkeep width.
WORD_W, DATA_W+KEEP_W+1, derived; queue word width.
CH_W, max(1,clog2(NUM_CH)), derived; tdest width.

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
ch_en  in  NUM_CH  per-channel grant enable
frame_q_empty  in  NUM_CH  per-channel queue empty
frame_q_read  out  NUM_CH  per-channel pop; one-hot or zero
frame_q_dout  in  NUM_CH*WORD_W  channel c occupies bits [c*WORD_W +: WORD_W]; within a word: [DATA_W-1:0] tdata, [DATA_W+KEEP_W-1:DATA_W] tkeep, MSB tlast
so_tvalid  out  1  AXIS valid
so_tready  in  1  AXIS ready
so_tdata  out  DATA_W  AXIS data
so_tkeep  out  KEEP_W  AXIS keep
so_tlast  out  1  AXIS last
so_tdest  out  CH_W  source channel of the beat
frame_cnt  out  32  frames fully emitted (count of so_tlast beats accepted); wraps at 2^32

Behaviour:
- Queues are FWFT. The head word on dout is valid whenever empty=0. A pop consumes the head word in the same cycle.
- Skid buffer: 2 entries, occ in 0..2.
  - space = (occ<2).
  - A push happens on a queue pop.
  - A drain happens on so_tvalid && so_tready.
  - Push and drain may occur in the same cycle.
  - so_* always present the oldest entry. so_tvalid = (occ>0).
  - so_tdata/tkeep/tlast/tdest are stable while so_tvalid=1 and so_tready=0.
- Latency: a word popped in cycle t appears on so_* in cycle t+1 if occ was 0.
- With so_tready held at 1 and the granted queue non-empty, the block sustains 1 beat per cycle inside a frame.
- FSM states: IDLE, STREAM. Registers: gnt (CH_W), rr_ptr (CH_W).
- IDLE:
  - Candidates are channels with ch_en[c] && !frame_q_empty[c].
  - Select the first candidate found searching from rr_ptr upward, modulo NUM_CH.
  - If a candidate exists and space=1: pop its head in this cycle, set gnt=c, and tag the pushed entry with tdest=c.
  - If the popped word has tlast=0: go to STREAM.
  - If it has tlast=1 (single-word frame): stay in IDLE and set rr_ptr=(c+1) mod NUM_CH.
  - If no candidate exists or space=0: nothing happens.
- STREAM:
  - Pop from gnt when !frame_q_empty[gnt] && space.
  - ch_en is ignored; a frame in progress always completes.
  - Other channels are never popped.
  - When the popped word has tlast=1: go to IDLE and set rr_ptr=(gnt+1) mod NUM_CH.
  - An empty granted queue mid-frame stalls with no timeout.
- The block never pops past a tlast word. The next frame requires a new arbitration, which costs at most one input-side bubble; the skid buffer hides this bubble when so_tready=1.
- frame_cnt increments on every accepted beat with so_tlast=1.
- NUM_CH=1: rr_ptr and so_tdest are held at 0.
- Reset (rstn=0 at a clk edge): state=IDLE, rr_ptr=0, gnt=0, occ=0, so_tvalid=0, frame_q_read=0, frame_cnt=0. Buffer contents are don't-care.
  - A reset mid-frame discards buffered beats and abandons the partial frame.
  - Frame resynchronisation after reset is the upstream writer's responsibility.

Test Plan:
- NUM_CH=1, 3-word frame, tready=1: pops in cycles t, t+1, t+2; so_tvalid in t+1..t+3; tlast on beat 3; frame_cnt=1; tdest=0.
- NUM_CH=2, each channel holds two 2-word frames, tready=1: output order is ch0 F0, ch1 F0, ch0 F1, ch1 F1; no interleaving within a frame; tdest matches the source channel.
- Backpressure: tready=0 for 5 cycles in mid-frame. occ reaches 2 and pops stop; so_* stay stable; no data loss or duplication once tready returns to 1.
- Single-word frames on all 4 channels (NUM_CH=4), tready=1: grant order is 0,1,2,3,0; every beat has tlast=1; frame_cnt=5 after 5 frames.
- ch_en=2'b10 with both queues loaded: only ch1 is served. Clearing ch_en[1] mid-frame lets the current frame finish, then no further grants occur.
- Assert rstn=0 for 1 cycle mid-frame: the next cycle shows so_tvalid=0, frame_q_read=0, frame_cnt=0; arbitration restarts from ch0.
